// File: rtl/line_window_gen.sv
// Column-window generator: seven cascaded line buffers present the 8 vertically
// aligned pixels of each accepted column, one clock after the pixel arrives.
module line_window_gen #(
  parameter int DW    = 10,
  parameter int IMG_W = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_sof,
  input  logic          i_pix_en,
  input  logic [DW-1:0] i_pix_in,
  output logic [DW-1:0] o_dout1,
  output logic [DW-1:0] o_dout2,
  output logic [DW-1:0] o_dout3,
  output logic [DW-1:0] o_dout4,
  output logic [DW-1:0] o_dout5,
  output logic [DW-1:0] o_dout6,
  output logic [DW-1:0] o_dout7,
  output logic [DW-1:0] o_dout8,
  output logic [AW-1:0] o_col_out,
  output logic          o_dout_en
);

  logic [AW-1:0] r_col_cnt;
  logic [2:0]    r_row_cnt;
  logic [DW-1:0] r_pix;
  logic [AW-1:0] r_col_out;
  logic          r_dout_en;
  logic          r_wr_pend;
  logic [AW-1:0] r_wr_addr;

  logic          w_acc;
  logic [AW-1:0] w_col;
  logic [2:0]    w_row;
  logic          w_wrap;
  logic          w_bypass;
  logic [DW-1:0] w_q [7];

  // A pixel presented while reset is held is discarded.
  assign w_acc    = i_rst && i_pix_en;
  assign w_col    = i_sof ? '0 : r_col_cnt;
  assign w_row    = i_sof ? 3'd0 : r_row_cnt;
  assign w_wrap   = (w_col == AW'(IMG_W - 1));
  assign w_bypass = r_wr_pend && (r_wr_addr == w_col);

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_col_cnt <= '0;
      r_row_cnt <= 3'd0;
      r_pix     <= '0;
      r_col_out <= '0;
      r_dout_en <= 1'b0;
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_wr_pend <= w_acc;
      r_dout_en <= w_acc && (w_row == 3'd7);
      if (w_acc) begin
        r_col_cnt <= w_wrap ? '0 : w_col + 1'b1;
        r_row_cnt <= (w_wrap && (w_row != 3'd7)) ? w_row + 3'd1 : w_row;
        r_pix     <= i_pix_in;
        r_col_out <= w_col;
        r_wr_addr <= w_col;
      end
    end
  end

  // The cascade write lags the read by one cycle: the data written into lb(k)
  // is exactly what the output stage just captured from lb(k-1) (or the pixel),
  // so every RAM keeps a plain registered read. A same-address re-read right
  // after a mid-line sof is served from the pending write data.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_lb
      logic [DW-1:0] r_mem [IMG_W];
      logic [DW-1:0] r_q;
      logic [DW-1:0] w_wdata;

      if (gi == 0) begin : g_first
        assign w_wdata = r_pix;
      end else begin : g_rest
        assign w_wdata = w_q[gi-1];
      end

      always_ff @(posedge clk) begin
        if (r_wr_pend) begin
          r_mem[r_wr_addr] <= w_wdata;
        end
      end

      always_ff @(posedge clk) begin
        if (!i_rst) begin
          r_q <= '0;
        end else if (w_acc) begin
          r_q <= w_bypass ? w_wdata : r_mem[w_col];
        end
      end

      assign w_q[gi] = r_q;
    end
  endgenerate

  assign o_dout8   = r_pix;
  assign o_dout7   = w_q[0];
  assign o_dout6   = w_q[1];
  assign o_dout5   = w_q[2];
  assign o_dout4   = w_q[3];
  assign o_dout3   = w_q[4];
  assign o_dout2   = w_q[5];
  assign o_dout1   = w_q[6];
  assign o_col_out = r_col_out;
  assign o_dout_en = r_dout_en;

endmodule
